// File: rtl/dmem_ctrl.sv
// RV32I load/store data-memory controller: word-bus handshake with byte enables,
// store-lane replication, load alignment/extension, misalignment and timeout faults.
module dmem_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_en,
  input  logic            mem_wr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] dmem_data,
  output logic            fault_misaligned,
  output logic            fault_timeout,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      f3_q, f3_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdat_q, wdat_d;
  logic [XLEN-1:0] dmem_q, dmem_d;
  logic            fmis_q, fmis_d;
  logic            ftmo_q, ftmo_d;

  // Request decode; undefined width codes fall through to word
  logic            is_byte_c, is_half_c, misaligned_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wrep_c;

  always_comb begin
    is_byte_c    = (funct3[1:0] == 2'b00);
    is_half_c    = (funct3[1:0] == 2'b01);
    misaligned_c = (is_half_c & addr[0]) | (!is_byte_c && !is_half_c && (addr[1:0] != 2'b00));
    if (is_byte_c) begin
      be_c   = 4'b0001 << addr[1:0];
      wrep_c = XLEN'({4{wdata[7:0]}});
    end else if (is_half_c) begin
      be_c   = 4'b0011 << addr[1:0];
      wrep_c = XLEN'({2{wdata[15:0]}});
    end else begin
      be_c   = 4'b1111;
      wrep_c = wdata;
    end
  end

  // Load alignment and extension from the latched offset/width
  logic [7:0]      lbyte_c;
  logic [15:0]     lhalf_c;
  logic [XLEN-1:0] lfmt_c;

  always_comb begin
    lbyte_c = bus_rdata[8*off_q +: 8];
    lhalf_c = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  lfmt_c = {{(XLEN-8){lbyte_c[7]}}, lbyte_c};
      3'b100:  lfmt_c = {{(XLEN-8){1'b0}}, lbyte_c};
      3'b001:  lfmt_c = {{(XLEN-16){lhalf_c[15]}}, lhalf_c};
      3'b101:  lfmt_c = {{(XLEN-16){1'b0}}, lhalf_c};
      default: lfmt_c = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
      dmem_q  <= '0;
      fmis_q  <= 1'b0;
      ftmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      dmem_q  <= dmem_d;
      fmis_q  <= fmis_d;
      ftmo_q  <= ftmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    dmem_d  = dmem_q;
    fmis_d  = 1'b0;
    ftmo_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_en) begin
          if (misaligned_c) begin
            state_d = DONE;
            fmis_d  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            off_d   = addr[1:0];
            f3_d    = funct3;
            req_d   = 1'b1;
            we_d    = mem_wr;
            addr_d  = {addr[XLEN-1:2], 2'b00};
            be_d    = be_c;
            wdat_d  = wrep_c;
          end
        end
      end
      BUSY: begin
        // Ack takes priority over a timeout expiring in the same cycle
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) dmem_d = lfmt_c;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          dmem_d  = '0;
          ftmo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall            = ((state_q == IDLE) && mem_en) || (state_q == BUSY);
  assign dmem_data        = dmem_q;
  assign fault_misaligned = fmis_q;
  assign fault_timeout    = ftmo_q;
  assign bus_req          = req_q;
  assign bus_we           = we_q;
  assign bus_addr         = addr_q;
  assign bus_be           = be_q;
  assign bus_wdata        = wdat_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan accesses plus randomized
// accesses checked against an arithmetic reference model.
module tb_dmem_ctrl;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] dmem_data;
  logic        fault_misaligned;
  logic        fault_timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_dmem = '0;

  dmem_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .dmem_data(dmem_data),
    .fault_misaligned(fault_misaligned), .fault_timeout(fault_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Width class: 0 byte, 1 half, 2 word (undefined codes behave as word)
  function automatic int wclass(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 0;
    if (f3 == 3'd1 || f3 == 3'd5) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] v;
    case (wclass(f3))
      0: begin
        v = (rd >> (8 * off)) & 32'd255;
        if (f3 == 3'd0 && v > 32'd127) v = v - 32'd256;
      end
      1: begin
        v = (rd >> (16 * (off / 2))) & 32'd65535;
        if (f3 == 3'd1 && v > 32'd32767) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One access from IDLE; ack_at = BUSY cycle carrying the ack, 0 = never.
  task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_at, input bit hold);
    int          off, wc;
    bit          mis, acked;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    off    = int'(a % 4);
    wc     = wclass(f3);
    mis    = (wc == 1 && (off % 2) != 0) || (wc == 2 && off != 0);
    e_addr = a - (a % 4);
    if (wc == 0) begin
      e_be = 4'(1 << off);
      e_wd = (wd & 32'hFF) * 32'h01010101;
    end else if (wc == 1) begin
      e_be = 4'(3 << off);
      e_wd = (wd & 32'hFFFF) * 32'h00010001;
    end else begin
      e_be = 4'hF;
      e_wd = wd;
    end
    mem_en = 1'b1; mem_wr = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
    #1 chk("stall_accept", stall, 1);
    @(negedge clk);
    if (mis) begin
      chk("mis_stall", stall, 0);
      chk("mis_req", bus_req, 0);
      chk("mis_fault", fault_misaligned, 1);
      chk("mis_tmo", fault_timeout, 0);
      chk("mis_dmem", dmem_data, exp_dmem);
    end else begin
      acked = 1'b0;
      for (int k = 1; k <= int'(TO) && !acked; k++) begin
        chk("busy_stall", stall, 1);
        chk("busy_req", bus_req, 1);
        chk("busy_we", bus_we, 32'(wr));
        chk("busy_addr", bus_addr, e_addr);
        chk("busy_be", bus_be, 32'(e_be));
        chk("busy_wdata", bus_wdata, e_wd);
        chk("busy_fmis", fault_misaligned, 0);
        if (k == ack_at) begin
          bus_ack = 1'b1; bus_rdata = rd; acked = 1'b1;
        end else begin
          bus_ack = 1'b0; bus_rdata = $urandom;
        end
        @(negedge clk);
      end
      bus_ack = 1'b0;
      if (!acked) exp_dmem = '0;
      else if (!wr) exp_dmem = fmt(f3, off, rd);
      chk("done_stall", stall, 0);
      chk("done_req", bus_req, 0);
      chk("done_we", bus_we, 0);
      chk("done_dmem", dmem_data, exp_dmem);
      chk("done_tmo", fault_timeout, 32'(!acked));
      chk("done_fmis", fault_misaligned, 0);
    end
    @(posedge clk);
    #1;
    if (!hold) mem_en = 1'b0;
    chk("idle_fault", fault_misaligned | fault_timeout, 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_dmem", dmem_data, 0);
    chk("rst_fmis", fault_misaligned, 0);
    chk("rst_ftmo", fault_timeout, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed test-plan accesses
    access(0, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 1, 0);
    chk("lb_value", dmem_data, 32'hFFFFFF80);
    access(0, 3'b101, 32'h2002, 32'h0, 32'hF00D1234, 1, 0);
    chk("lhu_value", dmem_data, 32'h0000F00D);
    access(0, 3'b001, 32'h2002, 32'h0, 32'hF00D1234, 1, 0);
    chk("lh_value", dmem_data, 32'hFFFFF00D);
    access(1, 3'b000, 32'h11, 32'h123456AB, 32'h0, 1, 0);
    chk("sb_keeps_dmem", dmem_data, 32'hFFFFF00D);
    access(1, 3'b010, 32'h10, 32'h123456AB, 32'h0, 1, 0);
    access(0, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, 5, 0);
    access(0, 3'b010, 32'h3004, 32'h0, 32'h13579BDF, 0, 0);
    chk("tmo_dmem", dmem_data, 32'h0);
    access(0, 3'b100, 32'h3005, 32'h0, 32'h0000A500, int'(TO), 0);
    chk("ack_at_limit", dmem_data, 32'h000000A5);
    access(0, 3'b010, 32'h1002, 32'h0, 32'h0, 1, 0);
    access(0, 3'b101, 32'h1001, 32'h0, 32'h0, 1, 0);
    access(0, 3'b111, 32'h1002, 32'h0, 32'h0, 1, 0);

    // Back-to-back: mem_en held through DONE, next access accepted right after
    access(0, 3'b001, 32'h400, 32'h0, 32'h00008001, 1, 1);
    access(0, 3'b000, 32'h401, 32'h0, 32'h00007F00, 2, 1);
    access(0, 3'b010, 32'h404, 32'h0, 32'h89ABCDEF, 1, 0);

    // Randomized accesses
    repeat (60) begin
      logic [2:0] f3;
      int         ack_at;
      f3 = 3'($urandom_range(0, 7));
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      access(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, ack_at,
             1'($urandom_range(0, 1)));
    end

    // Reset in the middle of BUSY
    access(0, 3'b010, 32'h500, 32'h0, 32'hDEADBEEF, 1, 0);
    mem_en = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    chk("pre_rst_req", bus_req, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_we", bus_we, 0);
    chk("mid_rst_addr", bus_addr, 0);
    chk("mid_rst_be", bus_be, 0);
    chk("mid_rst_dmem", dmem_data, 0);
    chk("mid_rst_fault", fault_misaligned | fault_timeout, 0);
    chk("mid_rst_stall_idle", stall, 1);
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_dmem = '0;
    @(negedge clk);
    chk("post_rst_fault", fault_misaligned | fault_timeout, 0);
    access(0, 3'b001, 32'h602, 32'h0, 32'h9876ABCD, 2, 0);
    chk("post_rst_value", dmem_data, 32'hFFFF9876);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
